// File: rtl/writeback_arbiter.sv
// Write-side front end of the register file: merges ALU and buffered memory results
// into a single registered write port and reports pending destinations to the hazard unit.
module writeback_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int DEPTH      = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         aluValid,
    output logic                         aluReady,
    input  logic [ADDR_WIDTH-1:0]        aluAddress,
    input  logic [DATA_WIDTH-1:0]        aluData,
    input  logic                         memValid,
    output logic                         memReady,
    input  logic [ADDR_WIDTH-1:0]        memAddress,
    input  logic [DATA_WIDTH-1:0]        memData,
    output logic                         writeRegister,
    output logic [ADDR_WIDTH-1:0]        writeAddress,
    output logic [DATA_WIDTH-1:0]        writeData,
    input  logic [ADDR_WIDTH-1:0]        queryAddress,
    output logic                         queryPending,
    output logic [$clog2(DEPTH):0]       bufferCount
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    entry_t            entries [DEPTH];
    logic [DEPTH-1:0]  valid;
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic [CW-1:0]     count;

    logic              full;
    logic              mem_xfer;
    logic              alu_xfer;
    logic              push;
    logic              enq;
    logic              pop;
    logic              bypass;
    logic              wr_en_next;
    logic [ADDR_WIDTH-1:0] wr_addr_next;
    logic [DATA_WIDTH-1:0] wr_data_next;

    assign full        = (count == CW'(DEPTH));
    assign memReady    = (count < CW'(DEPTH));
    assign aluReady    = !full;
    assign bufferCount = count;

    assign mem_xfer = memValid && memReady;
    assign alu_xfer = aluValid && aluReady;
    // x0 results complete their handshake but never occupy the buffer.
    assign push     = mem_xfer && (memAddress != '0);

    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        pop          = 1'b0;
        bypass       = 1'b0;
        wr_en_next   = 1'b0;
        wr_addr_next = '0;
        wr_data_next = '0;
        if (full) begin
            pop          = 1'b1;
            wr_en_next   = 1'b1;
            wr_addr_next = entries[rd_ptr].addr;
            wr_data_next = entries[rd_ptr].data;
        end else if (alu_xfer) begin
            if (aluAddress != '0) begin
                wr_en_next   = 1'b1;
                wr_addr_next = aluAddress;
                wr_data_next = aluData;
            end
        end else if (count != '0) begin
            pop          = 1'b1;
            wr_en_next   = 1'b1;
            wr_addr_next = entries[rd_ptr].addr;
            wr_data_next = entries[rd_ptr].data;
        end else if (push) begin
            // Empty buffer and idle ALU: forward straight through, moving both pointers.
            bypass       = 1'b1;
            wr_en_next   = 1'b1;
            wr_addr_next = memAddress;
            wr_data_next = memData;
        end
    end

    assign enq = push && !bypass;

    // NOTE: the payload array has no reset; the valid bits and count decide what is live.
    always_ff @(posedge clk) begin
        if (enq) begin
            entries[wr_ptr] <= '{addr: memAddress, data: memData};
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid         <= '0;
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            count         <= '0;
            writeRegister <= 1'b0;
            writeAddress  <= '0;
            writeData     <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop || bypass) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (pop) begin
                valid[rd_ptr] <= 1'b0;
            end
            if (enq) begin
                valid[wr_ptr] <= 1'b1;
            end
            count         <= count + CW'(enq) - CW'(pop);
            writeRegister <= wr_en_next;
            writeAddress  <= wr_addr_next;
            writeData     <= wr_data_next;
        end
    end

    always_comb begin
        queryPending = writeRegister && (writeAddress == queryAddress);
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i] && (entries[i].addr == queryAddress)) begin
                queryPending = 1'b1;
            end
        end
        if (queryAddress == '0) begin
            queryPending = 1'b0;
        end
    end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter: a table of per-cycle vectors plus
// hand-written wrap-around and mid-stream reset sequences.
module tb_writeback_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        aluValid, aluReady, memValid, memReady;
    logic [4:0]  aluAddress, memAddress, writeAddress, queryAddress;
    logic [31:0] aluData, memData, writeData;
    logic        writeRegister, queryPending;
    logic [1:0]  bufferCount;

    int tests = 0;
    int fails = 0;

    logic [31:0] regs [32];

    writeback_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .DEPTH(2)) dut (
        .clk(clk), .reset(reset),
        .aluValid(aluValid), .aluReady(aluReady), .aluAddress(aluAddress), .aluData(aluData),
        .memValid(memValid), .memReady(memReady), .memAddress(memAddress), .memData(memData),
        .writeRegister(writeRegister), .writeAddress(writeAddress), .writeData(writeData),
        .queryAddress(queryAddress), .queryPending(queryPending), .bufferCount(bufferCount)
    );

    always #5 clk = ~clk;

    // Downstream register file: commits on the edge after writeRegister is seen.
    always @(posedge clk) begin
        if (reset && writeRegister && writeAddress != 5'd0) regs[writeAddress] <= writeData;
    end

    typedef struct packed {
        logic        av;  logic [4:0] aa; logic [31:0] ad;
        logic        mv;  logic [4:0] ma; logic [31:0] md;
        logic [4:0]  qa;
        logic        ew;  logic [4:0] ea; logic [31:0] ed;
        logic [1:0]  ec;  logic emr; logic ear; logic eqp;
    } vec_t;

    vec_t vec [22];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                         input logic mv, input logic [4:0] ma, input logic [31:0] md,
                         input logic [4:0] qa);
        aluValid = av; aluAddress = aa; aluData = ad;
        memValid = mv; memAddress = ma; memData = md;
        queryAddress = qa;
    endtask

    task automatic check_write(input string tag, input logic ew, input logic [4:0] ea,
                               input logic [31:0] ed, input logic [1:0] ec);
        check({tag, " writeRegister"}, writeRegister, ew);
        if (ew) begin
            check({tag, " writeAddress"}, writeAddress, ea);
            check({tag, " writeData"}, writeData, ed);
        end
        check({tag, " bufferCount"}, bufferCount, ec);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = '0;
        reset = 1'b0;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0);

        //        av    aa     ad             mv    ma     md           qa     ew    ea     ed             ec    mr    ar    qp
        vec[0]  = '{1'b1, 5'd5,  32'h000000FF, 1'b0, 5'd0,  32'h0,       5'd5,  1'b1, 5'd5,  32'h000000FF, 2'd0, 1'b1, 1'b1, 1'b1};
        vec[1]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,       5'd5,  1'b0, 5'd0,  32'h0,        2'd0, 1'b1, 1'b1, 1'b0};
        vec[2]  = '{1'b1, 5'd10, 32'h88888888, 1'b1, 5'd7,  32'h1234,    5'd7,  1'b1, 5'd10, 32'h88888888, 2'd1, 1'b1, 1'b1, 1'b1};
        vec[3]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,       5'd7,  1'b1, 5'd7,  32'h1234,     2'd0, 1'b1, 1'b1, 1'b1};
        vec[4]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,       5'd7,  1'b0, 5'd0,  32'h0,        2'd0, 1'b1, 1'b1, 1'b0};
        vec[5]  = '{1'b1, 5'd3,  32'hA3,       1'b1, 5'd1,  32'h1111,    5'd1,  1'b1, 5'd3,  32'hA3,       2'd1, 1'b1, 1'b1, 1'b1};
        vec[6]  = '{1'b1, 5'd4,  32'hA4,       1'b1, 5'd2,  32'h2222,    5'd2,  1'b1, 5'd4,  32'hA4,       2'd2, 1'b0, 1'b0, 1'b1};
        vec[7]  = '{1'b1, 5'd6,  32'hA6,       1'b1, 5'd9,  32'h9999,    5'd2,  1'b1, 5'd1,  32'h1111,     2'd1, 1'b1, 1'b1, 1'b1};
        vec[8]  = '{1'b1, 5'd6,  32'hA6,       1'b0, 5'd0,  32'h0,       5'd2,  1'b1, 5'd6,  32'hA6,       2'd1, 1'b1, 1'b1, 1'b1};
        vec[9]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,       5'd2,  1'b1, 5'd2,  32'h2222,     2'd0, 1'b1, 1'b1, 1'b1};
        vec[10] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,       5'd2,  1'b0, 5'd0,  32'h0,        2'd0, 1'b1, 1'b1, 1'b0};
        vec[11] = '{1'b1, 5'd0,  32'h11111111, 1'b1, 5'd0,  32'h22222222, 5'd0, 1'b0, 5'd0,  32'h0,        2'd0, 1'b1, 1'b1, 1'b0};
        vec[12] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,       5'd0,  1'b0, 5'd0,  32'h0,        2'd0, 1'b1, 1'b1, 1'b0};
        vec[13] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd8,  32'h8888,    5'd8,  1'b1, 5'd8,  32'h8888,     2'd0, 1'b1, 1'b1, 1'b1};
        vec[14] = '{1'b1, 5'd11, 32'hB,        1'b1, 5'd12, 32'hC,       5'd12, 1'b1, 5'd11, 32'hB,        2'd1, 1'b1, 1'b1, 1'b1};
        vec[15] = '{1'b1, 5'd0,  32'hDEAD,     1'b0, 5'd0,  32'h0,       5'd12, 1'b0, 5'd0,  32'h0,        2'd1, 1'b1, 1'b1, 1'b1};
        vec[16] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,       5'd12, 1'b1, 5'd12, 32'hC,        2'd0, 1'b1, 1'b1, 1'b1};
        vec[17] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,       5'd12, 1'b0, 5'd0,  32'h0,        2'd0, 1'b1, 1'b1, 1'b0};
        vec[18] = '{1'b1, 5'd13, 32'hD,        1'b1, 5'd14, 32'hE,       5'd14, 1'b1, 5'd13, 32'hD,        2'd1, 1'b1, 1'b1, 1'b1};
        vec[19] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd15, 32'hF,       5'd15, 1'b1, 5'd14, 32'hE,        2'd1, 1'b1, 1'b1, 1'b1};
        vec[20] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,       5'd15, 1'b1, 5'd15, 32'hF,        2'd0, 1'b1, 1'b1, 1'b1};
        vec[21] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,       5'd15, 1'b0, 5'd0,  32'h0,        2'd0, 1'b1, 1'b1, 1'b0};

        // Held in reset across an edge: everything cleared, both sides ready.
        step();
        check("reset writeRegister", writeRegister, 1'b0);
        check("reset writeAddress", writeAddress, 5'd0);
        check("reset writeData", writeData, 32'd0);
        check("reset bufferCount", bufferCount, 2'd0);
        check("reset memReady", memReady, 1'b1);
        check("reset aluReady", aluReady, 1'b1);
        #5 reset = 1'b1;
        #1;

        for (int i = 0; i < 22; i++) begin
            string tag;
            tag = $sformatf("row%0d", i);
            drive(vec[i].av, vec[i].aa, vec[i].ad, vec[i].mv, vec[i].ma, vec[i].md, vec[i].qa);
            step();
            check_write(tag, vec[i].ew, vec[i].ea, vec[i].ed, vec[i].ec);
            check({tag, " memReady"}, memReady, vec[i].emr);
            check({tag, " aluReady"}, aluReady, vec[i].ear);
            check({tag, " queryPending"}, queryPending, vec[i].eqp);
        end
        check("regfile x5", regs[5], 32'h000000FF);
        check("regfile x7", regs[7], 32'h00001234);
        check("regfile x0", regs[0], 32'h0);

        // Wrap-around through real storage: an x0 ALU op forces x1 into the buffer,
        // then each new result pushes while the previous one pops.
        drive(1'b1, 5'd0, 32'h0, 1'b1, 5'd1, 32'hC0DE0001, 5'd1);
        step();
        check_write("wrap0", 1'b0, 5'd0, 32'h0, 2'd1);
        check("wrap0 queryPending", queryPending, 1'b1);
        for (int k = 1; k <= 8; k++) begin
            logic [31:0] d;
            d = 32'hC0DE0000 + 32'(k);
            if (k < 8) drive(1'b0, 5'd0, 32'h0, 1'b1, 5'(k + 1), d + 32'd1, 5'(k));
            else       drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'(k));
            step();
            check_write($sformatf("wrap%0d", k), 1'b1, 5'(k), d, (k < 8) ? 2'd1 : 2'd0);
        end
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0);
        step();
        check_write("wrap idle", 1'b0, 5'd0, 32'h0, 2'd0);

        // Mid-stream reset with two buffered entries.
        drive(1'b1, 5'd16, 32'h16, 1'b1, 5'd20, 32'h2020, 5'd20);
        step();
        drive(1'b1, 5'd17, 32'h17, 1'b1, 5'd21, 32'h2121, 5'd20);
        step();
        check_write("prefill", 1'b1, 5'd17, 32'h17, 2'd2);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd20);
        #3 reset = 1'b0;
        #1;
        check("midrst writeRegister", writeRegister, 1'b0);
        check("midrst writeAddress", writeAddress, 5'd0);
        check("midrst writeData", writeData, 32'd0);
        check("midrst bufferCount", bufferCount, 2'd0);
        check("midrst memReady", memReady, 1'b1);
        check("midrst aluReady", aluReady, 1'b1);
        check("midrst queryPending", queryPending, 1'b0);
        #2 reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check_write($sformatf("postrst%0d", k), 1'b0, 5'd0, 32'h0, 2'd0);
        end
        check("regfile x20 untouched", regs[20], 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
